gon_bus_dispatcher: RTL and testbench
=====================================

# gon_bus_dispatcher

Upstream stage of the GON multicast controllers. It buffers tagged packets from the global buffer side in a 2-entry FIFO and broadcasts the head packet's tag, data and valid to NUM_DEST multicast controllers on one bus. It retires a packet only when every controller whose ID matches the tag is ready in the same cycle, so a multicast is never duplicated or partially delivered. A packet that matches no controller is dropped.

## Interface
- NUM_DEST, 6, number of multicast controllers on the bus
- ID_SIZE, `XID_BITS, tag/ID width
- DATA_SIZE, 32, payload width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream packet valid
- in_ready  out  1  upstream ready; transfer on in_valid && in_ready
- in_tag  in  ID_SIZE  destination tag
- in_data  in  DATA_SIZE  payload
- bus_valid  out  1  broadcast valid to every controller's valid_in
- bus_tag  out  ID_SIZE  broadcast tag to every controller's tag input
- bus_data  out  DATA_SIZE  broadcast payload
- dest_id  in  NUM_DEST*ID_SIZE  configured ID of each controller; slice i = controller i
- dest_ready  in  NUM_DEST  ready_out of each controller; already 0 when its ID does not match
- drop_cnt  out  16  count of dropped, unmatched packets
- match_mask  out  NUM_DEST  combinational: bit i = bus_valid && dest_id[i] == bus_tag

## Operation
- FIFO
  - 2 entries, each holding tag and data.
  - Write pointer, read pointer and 2-bit count. Pointers are 1 bit and wrap 1→0.
  - in_ready = (count != 2).
- Bus outputs
  - bus_valid = (count != 0).
  - bus_tag and bus_data come from the head entry. They are driven from the storage registers with no combinational path from in_*.
- match = match_mask; all_rdy = &(dest_ready | ~match).
- Retire conditions
  - fire = bus_valid && (match != 0) && all_rdy.
  - drop = bus_valid && (match == 0).
  - Either one pops the head.
- Simultaneous push and pop
  - When count == 2, in_ready is already low, so no push can occur.
  - When count == 1 or 0, push and pop in the same cycle are legal. Count is unchanged at 1. At 0, pop is impossible, so count becomes 1.
- Blocked multicast
  - If any matching destination is not ready, the head is held with bus_valid high and tag/data stable. This is independent of how many cycles it waits.
  - The controller passes valid to its PE only when matched. With no partial retire, each matching PE sees exactly one accepted beat per packet.
- dest_id may change only while bus_valid is low (configuration phase). Behaviour for dest_id changes while bus_valid is high is undefined.

## Timing
- Reset values: count = 0, pointers = 0, bus_valid = 0, in_ready = 1, bus_tag = 0, bus_data = 0, drop_cnt = 0.
- Latency
  - A packet accepted at edge N is on the bus from cycle N+1.
  - A fire or drop at edge M exposes the next entry, if present, in cycle M+1.
- Throughput: one packet per cycle when all matched destinations hold ready high.
- Drop: takes exactly one cycle of bus_valid.
- Reset mid-operation: FIFO contents are discarded and bus_valid drops immediately (asynchronous). Packets in flight are lost; no recovery.

## Configuration
- GON_DROP_CNT_EN defined
  - drop_cnt increments by 1 on every drop.
  - It saturates at 16'hFFFF and clears only on rst.
- GON_DROP_CNT_EN undefined
  - No counter register; drop_cnt is tied to 0.
  - Drop behaviour is otherwise identical.

## Test plan
- Unicast: NUM_DEST=6, IDs 0..5. Push tag=3, data=32'hA5A5_0003 with all dest_ready high → bus_valid for 1 cycle, match_mask=6'b001000, FIFO empty after.
- Multicast stall: IDs {1,1,2,1,0,0}. Push tag=1. Hold dest_ready[3]=0 for 4 cycles while dest_ready[0] and dest_ready[1] are high → packet stays on bus for 5 cycles, retires on the cycle dest_ready[3] rises, exactly one retire.
- Backpressure: push 3 packets back-to-back while all dests are stalled → in_ready low after the 2nd. Release → packets appear in order, one per cycle, and the 3rd is accepted the cycle after the first retire.
- Unmatched: push tag=7 with no ID 7 → drop in 1 cycle. With GON_DROP_CNT_EN, drop_cnt=1; without it, drop_cnt=0.
- Saturation (GON_DROP_CNT_EN): 65 537 unmatched packets → drop_cnt=16'hFFFF.
- Async reset: assert rst with count=2 mid-stall → bus_valid=0, in_ready=1 without waiting for a clock edge. After deassert, one push is seen on the bus one cycle later.

Source files
------------

// File: rtl/gon_bus_dispatcher.sv
// ---------------------------------------------------------------------------
// gon_bus_dispatcher
//
// Purpose:
//   Upstream stage of the GON multicast controllers. Tagged packets from the
//   global buffer side are held in a 2-entry FIFO. The head packet's tag,
//   data and valid are broadcast on a single bus to NUM_DEST multicast
//   controllers. The head retires only when every controller whose ID
//   matches the tag is ready in the same cycle, so a multicast is never
//   duplicated or partially delivered. A packet that matches no controller
//   is dropped after a single cycle on the bus.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   in_valid    in   upstream packet valid
//   in_ready    out  upstream ready (transfer on in_valid && in_ready)
//   in_tag      in   destination tag   [ID_SIZE]
//   in_data     in   payload           [DATA_SIZE]
//   bus_valid   out  broadcast valid to every controller
//   bus_tag     out  broadcast tag     [ID_SIZE]
//   bus_data    out  broadcast payload [DATA_SIZE]
//   dest_id     in   configured ID per controller, slice i = controller i
//   dest_ready  in   ready of each controller
//   drop_cnt    out  count of dropped (unmatched) packets [16]
//   match_mask  out  combinational: bit i = bus_valid && dest_id[i] == bus_tag
//
// Build options:
//   GON_DROP_CNT_EN  when defined, drop_cnt is a saturating 16-bit counter of
//                    dropped packets; otherwise drop_cnt is tied to 0.
// ---------------------------------------------------------------------------
`ifndef XID_BITS
`define XID_BITS 3
`endif

module gon_bus_dispatcher #(
    parameter int NUM_DEST  = 6,
    parameter int ID_SIZE   = `XID_BITS,
    parameter int DATA_SIZE = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ID_SIZE-1:0]           in_tag,
    input  logic [DATA_SIZE-1:0]         in_data,
    output logic                         bus_valid,
    output logic [ID_SIZE-1:0]           bus_tag,
    output logic [DATA_SIZE-1:0]         bus_data,
    input  logic [NUM_DEST*ID_SIZE-1:0]  dest_id,
    input  logic [NUM_DEST-1:0]          dest_ready,
    output logic [15:0]                  drop_cnt,
    output logic [NUM_DEST-1:0]          match_mask
);

    // FIFO storage and bookkeeping
    logic [ID_SIZE-1:0]   r_tag  [2];
    logic [DATA_SIZE-1:0] r_data [2];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_count;

    logic w_push;
    logic w_pop;
    logic w_fire;
    logic w_drop;
    logic w_all_rdy;

    assign in_ready  = (r_count != 2'd2);
    assign bus_valid = (r_count != 2'd0);

    // Bus fields come straight from storage, so downstream timing never sees
    // a path from the upstream inputs.
    assign bus_tag  = r_tag[r_rptr];
    assign bus_data = r_data[r_rptr];

    always_comb begin
        match_mask = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            match_mask[i] = bus_valid && (dest_id[i*ID_SIZE +: ID_SIZE] == bus_tag);
        end
    end

    // Non-matching controllers are treated as ready so only the matched set
    // gates the retire; this keeps a multicast all-or-nothing.
    assign w_all_rdy = &(dest_ready | ~match_mask);
    assign w_fire    = bus_valid && (match_mask != '0) && w_all_rdy;
    assign w_drop    = bus_valid && (match_mask == '0);
    assign w_pop     = w_fire || w_drop;
    assign w_push    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (w_push) begin
            r_tag[r_wptr]  <= in_tag;
            r_data[r_wptr] <= in_data;
        end
    end

    // 1-bit pointers wrap naturally; count only moves when exactly one of
    // push/pop happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            r_wptr <= r_wptr ^ w_push;
            r_rptr <= r_rptr ^ w_pop;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef GON_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating drop counter; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_gon_bus_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_gon_bus_dispatcher
//
// Directed testbench for gon_bus_dispatcher. A queue-based model of the
// dispatcher runs alongside the DUT and a compare process checks the bus
// outputs against it every cycle; directed scenarios add literal checks.
// ---------------------------------------------------------------------------
`ifndef XID_BITS
`define XID_BITS 3
`endif

module tb_gon_bus_dispatcher;

    localparam int ND  = 6;
    localparam int IDW = `XID_BITS;
    localparam int DW  = 32;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [IDW-1:0]      in_tag;
    logic [DW-1:0]       in_data;
    logic                bus_valid;
    logic [IDW-1:0]      bus_tag;
    logic [DW-1:0]       bus_data;
    logic [ND*IDW-1:0]   dest_id;
    logic [ND-1:0]       dest_ready;
    logic [15:0]         drop_cnt;
    logic [ND-1:0]       match_mask;

    int compCnt = 0;
    int errCnt  = 0;
    bit chkEn   = 0;

    gon_bus_dispatcher #(
        .NUM_DEST  (ND),
        .ID_SIZE   (IDW),
        .DATA_SIZE (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tag     (in_tag),
        .in_data    (in_data),
        .bus_valid  (bus_valid),
        .bus_tag    (bus_tag),
        .bus_data   (bus_data),
        .dest_id    (dest_id),
        .dest_ready (dest_ready),
        .drop_cnt   (drop_cnt),
        .match_mask (match_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [IDW-1:0] tag;
        logic [DW-1:0]  data;
    } pkt_t;

    pkt_t        mq[$];
    logic [15:0] mDrop;
    logic [ND-1:0] mMatch;
    bit          mPush;
    bit          mPop;
    bit          mDropNow;

    // Which controllers the head packet addresses under the current IDs.
    function automatic logic [ND-1:0] modelMatch();
        logic [ND-1:0] m;
        m = '0;
        if (mq.size() != 0) begin
            for (int i = 0; i < ND; i++) begin
                if (dest_id[i*IDW +: IDW] == mq[0].tag) m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Advance the model one clock: decide retire/drop and accept from the
    // state before the edge, then apply pop before push.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mDrop = 16'd0;
        end else begin
            mMatch   = modelMatch();
            mPush    = in_valid && (mq.size() < 2);
            mDropNow = (mq.size() != 0) && (mMatch == '0);
            mPop     = (mq.size() != 0) && (mDropNow || ((dest_ready & mMatch) == mMatch));
`ifdef GON_DROP_CNT_EN
            if (mDropNow && mDrop != 16'hFFFF) mDrop = mDrop + 16'd1;
`endif
            if (mPop) void'(mq.pop_front());
            if (mPush) mq.push_back('{tag: in_tag, data: in_data});
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chkEn && !rst) begin
            checkOutput("model bus_valid", {63'd0, bus_valid}, {63'd0, mq.size() != 0});
            checkOutput("model in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 2});
            checkOutput("model match_mask", 64'(match_mask), 64'(modelMatch()));
            checkOutput("model drop_cnt", 64'(drop_cnt), 64'(mDrop));
            if (mq.size() != 0) begin
                checkOutput("model bus_tag", 64'(bus_tag), 64'(mq[0].tag));
                checkOutput("model bus_data", 64'(bus_data), 64'(mq[0].data));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic applyStimulus(input logic v, input logic [IDW-1:0] t, input logic [DW-1:0] d);
        in_valid = v;
        in_tag   = t;
        in_data  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int idsSeq[ND]   = '{0, 1, 2, 3, 4, 5};
    int idsMulti[ND] = '{1, 1, 2, 1, 0, 0};

    task automatic setSeqIds();
        for (int i = 0; i < ND; i++) dest_id[i*IDW +: IDW] = idsSeq[i][IDW-1:0];
    endtask

    task automatic setMultiIds();
        for (int i = 0; i < ND; i++) dest_id[i*IDW +: IDW] = idsMulti[i][IDW-1:0];
    endtask

    int vcnt;
    int acceptK;
    logic [IDW-1:0] seen[$];

    initial begin
        rst        = 1'b1;
        dest_ready = '0;
        dest_id    = '0;
        applyStimulus(1'b0, '0, '0);
        setSeqIds();
        #3;
        $display("[TB] reset values");
        checkOutput("reset bus_valid", {63'd0, bus_valid}, 64'd0);
        checkOutput("reset in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset bus_tag", 64'(bus_tag), 64'd0);
        checkOutput("reset bus_data", 64'(bus_data), 64'd0);
        checkOutput("reset drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chkEn = 1'b1;
        step();

        // Unicast to controller 3.
        $display("[TB] unicast");
        dest_ready = '1;
        applyStimulus(1'b1, 3, 32'hA5A5_0003);
        step();
        applyStimulus(1'b0, '0, '0);
        @(negedge clk);
        checkOutput("uni bus_valid", {63'd0, bus_valid}, 64'd1);
        checkOutput("uni match_mask", 64'(match_mask), 64'b001000);
        checkOutput("uni bus_data", 64'(bus_data), 64'hA5A5_0003);
        step();
        @(negedge clk);
        checkOutput("uni empty after", {63'd0, bus_valid}, 64'd0);
        step();

        // Multicast to controllers 0,1,3 with controller 3 stalling 4 cycles.
        $display("[TB] multicast stall");
        setMultiIds();
        dest_ready = 6'b000011;
        applyStimulus(1'b1, 1, 32'h1111_2222);
        step();
        applyStimulus(1'b0, '0, '0);
        vcnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus_valid) vcnt++;
            step();
        end
        dest_ready = 6'b001011;
        @(negedge clk);
        if (bus_valid) vcnt++;
        checkOutput("mc stall match_mask", 64'(match_mask), 64'b001011);
        step();
        @(negedge clk);
        checkOutput("mc cycles on bus", 64'(vcnt), 64'd5);
        checkOutput("mc single retire", {63'd0, bus_valid}, 64'd0);
        step();

        // Backpressure: three back-to-back packets while all stalled.
        $display("[TB] backpressure");
        setSeqIds();
        dest_ready = '0;
        applyStimulus(1'b1, 0, 32'hB000_0000);
        step();
        applyStimulus(1'b1, 1, 32'hB000_0001);
        step();
        applyStimulus(1'b1, 2, 32'hB000_0002);
        @(negedge clk);
        checkOutput("bp in_ready low", {63'd0, in_ready}, 64'd0);
        step();
        dest_ready = '1;
        acceptK = -1;
        seen.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus_valid) seen.push_back(bus_tag);
            if (in_valid && in_ready && acceptK < 0) acceptK = k;
            step();
            if (acceptK >= 0) applyStimulus(1'b0, '0, '0);
        end
        checkOutput("bp accept cycle", 64'(acceptK), 64'd1);
        checkOutput("bp seen count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            checkOutput("bp order 0", 64'(seen[0]), 64'd0);
            checkOutput("bp order 1", 64'(seen[1]), 64'd1);
            checkOutput("bp order 2", 64'(seen[2]), 64'd2);
        end
        applyStimulus(1'b0, '0, '0);

        // Unmatched tag is dropped after one cycle.
        $display("[TB] unmatched");
        applyStimulus(1'b1, 7, 32'hDEAD_0007);
        step();
        applyStimulus(1'b0, '0, '0);
        @(negedge clk);
        checkOutput("drop bus_valid", {63'd0, bus_valid}, 64'd1);
        checkOutput("drop match_mask", 64'(match_mask), 64'd0);
        step();
        @(negedge clk);
        checkOutput("drop gone", {63'd0, bus_valid}, 64'd0);
`ifdef GON_DROP_CNT_EN
        checkOutput("drop_cnt one", 64'(drop_cnt), 64'd1);
`else
        checkOutput("drop_cnt tied", 64'(drop_cnt), 64'd0);
`endif
        step();

        // Asynchronous reset with the FIFO full and stalled.
        $display("[TB] async reset");
        dest_ready = '0;
        applyStimulus(1'b1, 1, 32'hC000_0001);
        step();
        applyStimulus(1'b1, 2, 32'hC000_0002);
        step();
        applyStimulus(1'b0, '0, '0);
        @(negedge clk);
        checkOutput("pre-reset full", {63'd0, in_ready}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async bus_valid", {63'd0, bus_valid}, 64'd0);
        checkOutput("async in_ready", {63'd0, in_ready}, 64'd1);
        #3;
        rst = 1'b0;
        step();
        dest_ready = '1;
        applyStimulus(1'b1, 4, 32'hC000_0004);
        step();
        applyStimulus(1'b0, '0, '0);
        @(negedge clk);
        checkOutput("post-reset bus_valid", {63'd0, bus_valid}, 64'd1);
        checkOutput("post-reset bus_tag", 64'(bus_tag), 64'd4);
        step();
        step();

`ifdef GON_DROP_CNT_EN
        // Stream of unmatched packets saturates the counter.
        $display("[TB] saturation");
        applyStimulus(1'b1, 7, 32'h0);
        repeat (65537) step();
        applyStimulus(1'b0, '0, '0);
        step();
        step();
        @(negedge clk);
        checkOutput("drop_cnt saturated", 64'(drop_cnt), 64'hFFFF);
        step();
`endif

        chkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
        $finish;
    end

endmodule
